segled_value_ctrl: RTL
======================

Name: segled_value_ctrl

Overview:
- Wishbone32 master that turns a 16-bit hex value into register writes to the segled_wb32 display slave.
- Computes per-digit enable (leading-zero blanking, forced on by decimal point), writes the config word only when it changes, then writes the data word.
- Sits between a hardware status source (valid/ready stream) and the segled slave; the CPU does not touch the slave while this block owns it.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the segled slave; config register at BASE_ADDR, data register at BASE_ADDR+4.
- ACK_TIMEOUT, 16, maximum cycles a strobe may wait for wb_ack_i before the transfer is aborted (range 2..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- val_valid  in  1  new value offered
- val_ready  out  1  block can accept a value
- val_data  in  16  four hex digits; [3:0] is digit 0 (rightmost)
- val_dp  in  4  decimal point per digit
- val_blank_lz  in  1  blank leading zeros
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  write enable, always 1 while cyc
- wb_sel_o  out  4  byte select, 4'hF while cyc
- wb_adr_o  out  32  address
- wb_dat_o  out  32  write data
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  32  slave read data, unused
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag

Behaviour:
- Single clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: cyc/stb/we = 0, sel = 0, adr = 0, dat = 0, busy = 0, err = 0, val_ready = 1. Internal conf_valid = 0.
- States: IDLE, CONF, DATA.
- IDLE (val_ready = 1). On val_valid & val_ready:
  - Latch data, dp and blank_lz; clear err.
  - Compute en[i]: if blank_lz = 0, en[i] = 1. Otherwise en[0] = 1, and en[i] = 1 if any nibble j >= i is nonzero (i = 1..3).
  - Force en[i] = 1 when dp[i] = 1. Passthrough bits are always 0.
  - conf word = {7'b0, en3, 7'b0, en2, 7'b0, en1, 7'b0, en0}.
  - Go to CONF if conf_valid = 0 or conf word differs from last_conf; otherwise go to DATA.
- CONF:
  - Drive cyc = stb = we = 1, sel = F, adr = BASE_ADDR, dat = conf word.
  - On wb_ack_i: last_conf <= conf word, conf_valid <= 1, go to DATA. cyc/stb drop for exactly one cycle between the two writes.
- DATA:
  - Drive adr = BASE_ADDR+4; byte i of dat = {dp[i], 3'b000, nibble i}.
  - On wb_ack_i: drop cyc/stb, go to IDLE.
- Stay behaviour: stb is held until ack. A second ack cycle is ignored because the state has already advanced.
- Latency with a one-cycle-ack slave, accept at edge 0:
  - CONF strobe high in cycles 1-2, DATA strobe high in cycles 4-5.
  - val_ready high again in cycle 6. If CONF is skipped, val_ready returns in cycle 3.
- Timeout:
  - A counter resets on entry to CONF/DATA and increments each cycle without ack.
  - When it reaches ACK_TIMEOUT: cyc/stb <= 0, err <= 1, conf_valid <= 0, go to IDLE.
  - The latched value is dropped; the next accepted value always rewrites config.
- Ack outside CONF/DATA is ignored. val_valid while busy is not accepted (val_ready = 0).
- Reset mid-transfer: cyc/stb low on the next edge, state IDLE, conf_valid cleared.

Test Plan:
- Reset, then send val_data=16'h1234, dp=0, blank=0 -> write adr 0 dat 32'h01010101, then write adr 4 dat 32'h01020304; val_ready returns 6 cycles after accept.
- Follow with 16'hABCD, same flags -> no CONF write; single write adr 4 dat 32'h0A0B0C0D; ready after 3 cycles.
- 16'h0042 with blank=1 -> CONF dat 32'h00000101, DATA dat 32'h00000402. Then 16'h0000 with blank=1 -> CONF dat 32'h00000001, DATA dat 0.
- 16'h0005, blank=1, dp=4'b0100 -> CONF dat 32'h00010001, DATA dat 32'h00800005.
- Slave never acks, ACK_TIMEOUT=16 -> stb high exactly 16 cycles then low, err=1. Resending the previous value issues a CONF write again, and err clears on accept.
- Assert rst during the CONF strobe -> cyc/stb=0 on the next edge, busy=0, val_ready=1. The next value performs a CONF write.

Source files
------------

// File: rtl/segled_value_ctrl.sv
`timescale 1ns/1ps
// Wishbone master that converts a 16-bit hex value into config/data writes for the segled_wb32 slave.
// Config is written only when the computed digit-enable word changes; a stalled slave is abandoned after ACK_TIMEOUT cycles.
module segled_value_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        val_valid,
    output logic        val_ready,
    input  logic [15:0] val_data,
    input  logic [3:0]  val_dp,
    input  logic        val_blank_lz,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i,
    output logic        busy,
    output logic        err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONF = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    localparam logic [31:0] CONF_ADDR = BASE_ADDR;
    localparam logic [31:0] DATA_ADDR = BASE_ADDR + 32'd4;
    localparam logic [15:0] TMO_LAST  = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [15:0] data_q;
    logic [3:0]  dp_q;
    logic [31:0] conf_q;
    logic [31:0] last_conf;
    logic        conf_valid;
    logic [15:0] tmo_cnt;

    logic [31:0] conf_new;
    logic        need_conf;
    logic        tmo_hit;
    logic        unused_rd;

    assign unused_rd = ^wb_dat_i;

    // Leading-zero blanking keeps digit 0 lit; a decimal point always lights its digit.
    function automatic logic [31:0] make_conf(input logic [15:0] d, input logic [3:0] dp,
                                              input logic blank);
        logic [3:0] en;
        en[0] = 1'b1;
        en[1] = |d[15:4];
        en[2] = |d[15:8];
        en[3] = |d[15:12];
        if (!blank) begin
            en = 4'hF;
        end
        en = en | dp;
        return {7'b0, en[3], 7'b0, en[2], 7'b0, en[1], 7'b0, en[0]};
    endfunction

    function automatic logic [31:0] make_data(input logic [15:0] d, input logic [3:0] dp);
        return {dp[3], 3'b000, d[15:12], dp[2], 3'b000, d[11:8],
                dp[1], 3'b000, d[7:4],   dp[0], 3'b000, d[3:0]};
    endfunction

    always_comb begin
        conf_new  = make_conf(val_data, val_dp, val_blank_lz);
        need_conf = !conf_valid || (conf_new != last_conf);
        tmo_hit   = (tmo_cnt == TMO_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            data_q     <= '0;
            dp_q       <= '0;
            conf_q     <= '0;
            last_conf  <= '0;
            conf_valid <= 1'b0;
            tmo_cnt    <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= 4'h0;
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            busy       <= 1'b0;
            err        <= 1'b0;
            val_ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (val_valid && val_ready) begin
                        data_q    <= val_data;
                        dp_q      <= val_dp;
                        conf_q    <= conf_new;
                        err       <= 1'b0;
                        tmo_cnt   <= '0;
                        wb_cyc_o  <= 1'b1;
                        wb_stb_o  <= 1'b1;
                        wb_we_o   <= 1'b1;
                        wb_sel_o  <= 4'hF;
                        busy      <= 1'b1;
                        val_ready <= 1'b0;
                        if (need_conf) begin
                            state    <= S_CONF;
                            wb_adr_o <= CONF_ADDR;
                            wb_dat_o <= conf_new;
                        end else begin
                            state    <= S_DATA;
                            wb_adr_o <= DATA_ADDR;
                            wb_dat_o <= make_data(val_data, val_dp);
                        end
                    end
                end
                S_CONF: begin
                    if (wb_ack_i) begin
                        // Bus goes idle for one cycle; DATA raises the strobe again.
                        last_conf  <= conf_q;
                        conf_valid <= 1'b1;
                        state      <= S_DATA;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                        wb_sel_o   <= 4'h0;
                    end else if (tmo_hit) begin
                        state      <= S_IDLE;
                        conf_valid <= 1'b0;
                        err        <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                        wb_sel_o   <= 4'h0;
                        busy       <= 1'b0;
                        val_ready  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (!wb_stb_o) begin
                        tmo_cnt  <= '0;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= 1'b1;
                        wb_sel_o <= 4'hF;
                        wb_adr_o <= DATA_ADDR;
                        wb_dat_o <= make_data(data_q, dp_q);
                    end else if (wb_ack_i) begin
                        state     <= S_IDLE;
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        wb_sel_o  <= 4'h0;
                        busy      <= 1'b0;
                        val_ready <= 1'b1;
                    end else if (tmo_hit) begin
                        state      <= S_IDLE;
                        conf_valid <= 1'b0;
                        err        <= 1'b1;
                        wb_cyc_o   <= 1'b0;
                        wb_stb_o   <= 1'b0;
                        wb_we_o    <= 1'b0;
                        wb_sel_o   <= 4'h0;
                        busy       <= 1'b0;
                        val_ready  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    wb_cyc_o  <= 1'b0;
                    wb_stb_o  <= 1'b0;
                    busy      <= 1'b0;
                    val_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
